// File: rtl/unary_accum_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : unary_accum_multi                                            |
// | Description : Multi-channel unary pulse accumulator. In write mode the     |
// |               number of high din bits is added to a CNT_W-bit count each   |
// |               enabled cycle, with wrap or saturate overflow and a sticky   |
// |               overflow flag C. In read mode the count is drained back out  |
// |               as a train of one-cycle pulses on dout, and done rises once  |
// |               the count is empty.                                          |
// | Ports       : clk           - system clock, rising edge                    |
// |               rst           - asynchronous active-high reset               |
// |               en            - global enable (0 holds state, dout low)      |
// |               clr           - synchronous clear of count, C, done, dout    |
// |               din           - NUM_IN unary input channels                  |
// |               read_or_write - 0 = accumulate, 1 = drain                    |
// |               dout          - registered unary output pulse                |
// |               C             - sticky overflow flag                         |
// |               count         - current accumulator value                    |
// |               done          - drain has emptied the count                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module unary_accum_multi #(
    parameter int NUM_IN   = 4,
    parameter int CNT_W    = 11,
    parameter int SAT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_IN-1:0] din,
    input  logic              read_or_write,
    output logic              dout,
    output logic              C,
    output logic [CNT_W-1:0]  count,
    output logic              done
);

    localparam int             c_INC_W     = $clog2(NUM_IN + 1);
    localparam int             c_SUM_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Operating modes. The mode input is acted on in the same edge it is
    // sampled, so the mode value itself is the state: a separate state
    // register would only ever hold a copy that nothing reads.
    localparam logic [0:0] c_MODE_WRITE = 1'b0;
    localparam logic [0:0] c_MODE_READ  = 1'b1;

    logic [CNT_W-1:0]   r_count;
    logic               r_dout;
    logic               r_c;
    logic               r_done;

    logic [c_INC_W-1:0] w_inc;
    logic [c_SUM_W-1:0] w_sum;
    logic [CNT_W-1:0]   w_ovf_val;
    logic [CNT_W-1:0]   w_next_wr;
    logic               w_is_read;

    // Population count of the input channels.
    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_inc = w_inc + c_INC_W'(din[i]);
        end
    end

    // One extra bit on the sum so overflow is visible as the carry-out.
    assign w_sum = {1'b0, r_count} + c_SUM_W'(w_inc);

    generate
        if (SAT_MODE != 0) begin : g_sat
            assign w_ovf_val = c_CNT_MAX;
        end else begin : g_wrap
            assign w_ovf_val = w_sum[CNT_W-1:0];
        end
    endgenerate

    assign w_next_wr = w_sum[CNT_W] ? w_ovf_val : w_sum[CNT_W-1:0];
    assign w_is_read = (read_or_write == c_MODE_READ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_dout  <= 1'b0;
            r_c     <= 1'b0;
            r_done  <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_dout  <= 1'b0;
            r_c     <= 1'b0;
            r_done  <= 1'b0;
        end else if (!en) begin
            r_dout  <= 1'b0;
        end else if (w_is_read) begin
            // Drain: one pulse per unit of count; never underflows.
            if (r_count != '0) begin
                r_dout  <= 1'b1;
                r_count <= r_count - 1'b1;
                r_done  <= 1'b0;
            end else begin
                r_dout  <= 1'b0;
                r_done  <= 1'b1;
            end
        end else begin
            r_count <= w_next_wr;
            r_dout  <= 1'b0;
            r_done  <= 1'b0;
            if (w_sum[CNT_W]) begin
                r_c <= 1'b1;
            end
        end
    end

    assign count = r_count;
    assign dout  = r_dout;
    assign C     = r_c;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_unary_accum_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_unary_accum_multi                                         |
// | Description : Self-checking bench for unary_accum_multi. Drives a wrapping |
// |               and a saturating instance with identical directed stimulus,  |
// |               compares both against an arithmetic model every cycle, and   |
// |               pins the model with hand-computed literal expectations.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_unary_accum_multi;

    localparam int c_NUM_IN = 4;
    localparam int c_CNT_W  = 11;
    localparam int c_MAX    = (1 << c_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                clr;
    logic [c_NUM_IN-1:0] din;
    logic                rw;

    logic                dout_w, c_w, done_w;
    logic [c_CNT_W-1:0]  count_w;
    logic                dout_s, c_s, done_s;
    logic [c_CNT_W-1:0]  count_s;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt  [2] = '{0, 0};
    int m_c    [2] = '{0, 0};
    int m_done [2] = '{0, 0};
    int m_dout [2] = '{0, 0};

    always #5 clk = ~clk;

    unary_accum_multi #(.NUM_IN(c_NUM_IN), .CNT_W(c_CNT_W), .SAT_MODE(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .read_or_write(rw),
        .dout(dout_w), .C(c_w), .count(count_w), .done(done_w)
    );

    unary_accum_multi #(.NUM_IN(c_NUM_IN), .CNT_W(c_CNT_W), .SAT_MODE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .read_or_write(rw),
        .dout(dout_s), .C(c_s), .count(count_s), .done(done_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: plain integer arithmetic on the accumulated total.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || clr) begin
                m_cnt[k] = 0; m_c[k] = 0; m_done[k] = 0; m_dout[k] = 0;
            end else if (!en) begin
                m_dout[k] = 0;
            end else if (rw) begin
                if (m_cnt[k] > 0) begin
                    m_dout[k] = 1; m_cnt[k] = m_cnt[k] - 1; m_done[k] = 0;
                end else begin
                    m_dout[k] = 0; m_done[k] = 1;
                end
            end else begin
                int tot;
                tot = m_cnt[k] + $countones(din);
                if (tot > c_MAX) begin
                    m_c[k]   = 1;
                    m_cnt[k] = (k == 1) ? c_MAX : tot - (c_MAX + 1);
                end else begin
                    m_cnt[k] = tot;
                end
                m_dout[k] = 0; m_done[k] = 0;
            end
        end
    end

    // Per-cycle comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rst === 1'b0) begin
            chk("wrap_count", 32'(count_w), 32'(m_cnt[0]));
            chk("wrap_C",     32'(c_w),     32'(m_c[0]));
            chk("wrap_done",  32'(done_w),  32'(m_done[0]));
            chk("wrap_dout",  32'(dout_w),  32'(m_dout[0]));
            chk("sat_count",  32'(count_s), 32'(m_cnt[1]));
            chk("sat_C",      32'(c_s),     32'(m_c[1]));
            chk("sat_done",   32'(done_s),  32'(m_done[1]));
            chk("sat_dout",   32'(dout_s),  32'(m_dout[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int run;
        logic seq_ok;

        rst = 1'b1; en = 1'b0; clr = 1'b0; din = '0; rw = 1'b0;
        cyc(2);
        chk("rst_count", 32'(count_w), 0);
        chk("rst_dout",  32'(dout_w),  0);
        rst = 1'b0;

        // Read from empty count: done on first enabled read edge.
        en = 1'b1; rw = 1'b1;
        cyc(1);
        chk("empty_read_done", 32'(done_w), 1);
        chk("empty_read_dout", 32'(dout_w), 0);

        // Write 10 x 4 = 40, then drain.
        rw = 1'b0; din = 4'b1111;
        cyc(10);
        chk("w40_count", 32'(count_w), 40);
        chk("w40_C",     32'(c_w),     0);
        rw = 1'b1; din = '0;
        run = 0; seq_ok = 1'b1;
        for (int i = 0; i < 41; i++) begin
            cyc(1);
            if (dout_w) run++;
            if ((i < 40) != (dout_w === 1'b1)) seq_ok = 1'b0;
        end
        chk("drain40_run",   32'(run),     40);
        chk("drain40_seq",   32'(seq_ok),  1);
        chk("drain40_done",  32'(done_w),  1);
        chk("drain40_count", 32'(count_w), 0);

        // Asynchronous reset mid-drain at count 37.
        rw = 1'b0; din = 4'b1111;
        cyc(10);
        rw = 1'b1;
        cyc(3);
        chk("pre_rst_count", 32'(count_w), 37);
        chk("pre_rst_dout",  32'(dout_w),  1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_dout",  32'(dout_w),  0);
        chk("async_rst_count", 32'(count_w), 0);
        chk("async_rst_C",     32'(c_w),     0);
        chk("async_rst_done",  32'(done_w),  0);
        cyc(1);
        rst = 1'b0;

        // Enable freeze, partial drain, resume writing.
        rw = 1'b0; din = 4'b0101;
        cyc(10);
        chk("t4_w20", 32'(count_w), 20);
        en = 1'b0; din = 4'b1111;
        cyc(5);
        chk("t4_hold_count", 32'(count_w), 20);
        chk("t4_hold_dout",  32'(dout_w),  0);
        en = 1'b1; rw = 1'b1;
        cyc(5);
        chk("t4_r15", 32'(count_w), 15);
        rw = 1'b0; din = 4'b0011;
        cyc(3);
        chk("t4_w21",   32'(count_w), 21);
        chk("t4_done0", 32'(done_w),  0);

        // Overflow: 513 x 4 = 2052.
        clr = 1'b1;
        cyc(1);
        clr = 1'b0; din = 4'b1111;
        cyc(513);
        chk("wrap_ovf_count", 32'(count_w), 4);
        chk("wrap_ovf_C",     32'(c_w),     1);
        chk("sat_ovf_count",  32'(count_s), 2047);
        chk("sat_ovf_C",      32'(c_s),     1);
        cyc(2);
        chk("sat_hold_max", 32'(count_s), 2047);
        rw = 1'b1; din = '0;
        cyc(2048);
        chk("sat_drain_count", 32'(count_s), 0);
        chk("sat_drain_done",  32'(done_s),  1);
        chk("sat_drain_C",     32'(c_s),     1);

        // Clear wins over a simultaneous write.
        rw = 1'b0; din = 4'b1111; clr = 1'b1;
        cyc(1);
        chk("clr_count", 32'(count_w), 0);
        chk("clr_C",     32'(c_w),     0);
        chk("clr_sat_C", 32'(c_s),     0);
        clr = 1'b0;
        cyc(1);
        chk("post_clr_count", 32'(count_w), 4);

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
